load_buffer_ctrl: RTL and testbench
===================================

# load_buffer_ctrl

Load buffer and data-cache issue scheduler. Sits between the load address-generation stage and the data-cache load port. It accepts address-resolved loads, holds each until all older stores have drained from the store queue, then issues it to the cache. It tracks out-of-order cache responses by entry ID and reports completed loads to writeback. It also owns branch-mask maintenance and misprediction squash for every load it holds, including loads already in flight to the cache.

## Interface
- NUM_ENTRIES, 4, load buffer depth; power of two, at least 2; ID_W = log2(NUM_ENTRIES)
- ADDR_W, 32, load address width
- TAG_W, 6, physical destination register index width
- BM_W, 4, branch mask width
- SQ_W, 3, store queue index width

Ports (reset is synchronous and active-high; clock is `clock`):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  new load from the address stage
- alloc_addr  in  ADDR_W  load address
- alloc_dest  in  TAG_W  destination physical register
- alloc_bm  in  BM_W  branch mask
- alloc_sq_tail  in  SQ_W  store queue tail captured when the load was dispatched
- load_buffer_free  out  1  at least one FREE entry
- sq_head  in  SQ_W  current store queue head
- dcache_req_valid  out  1  load request to the cache
- dcache_req_addr  out  ADDR_W  request address
- dcache_req_id  out  ID_W  entry index, used as the request tag
- dcache_req_ready  in  1  cache accepts the request this cycle
- dcache_resp_valid  in  1  load data returned
- dcache_resp_id  in  ID_W  tag of the returned data
- dcache_resp_data  in  32  returned data
- done_valid  out  1  completed load
- done_dest  out  TAG_W  destination register of the completed load
- done_data  out  32  data of the completed load
- b_mm_resolve  in  BM_W  one-hot mask of the branch resolving this cycle
- b_mm_mispred  in  1  the resolving branch was mispredicted

## Operation
Each entry has the fields state, addr, dest, bm and sq_tail. The entry states are:
- FREE: entry holds no load.
- WAIT_SQ: load is waiting for older stores to drain.
- READY: load may be issued to the cache.
- ISSUED: request accepted by the cache; waiting for the response.
- ZOMBIE: load was squashed after issue; waiting for its response so it can be discarded.

Allocation:
- When alloc_valid=1 and load_buffer_free=1, write the lowest-index FREE entry and set it to WAIT_SQ.
- alloc_valid=1 while load_buffer_free=0 is a protocol violation. Ignore the request.

Store-order readiness:
- A WAIT_SQ entry moves to READY when sq_head == sq_tail.
- Use equality only, so index wrap-around needs no special handling.

Issue:
- dcache_req_valid is set when some READY entry is not killed this cycle. Select the lowest-index such entry.
- dcache_req_addr and dcache_req_id come combinationally from the selected entry.
- When dcache_req_valid=1 and dcache_req_ready=1, the selected entry moves to ISSUED.

Response:
- When dcache_resp_valid=1 and the ID'd entry is ISSUED, free the entry. On the next cycle, pulse done_valid with that entry's dest and the response data.
- If the ID'd entry is ZOMBIE, free it and produce no done_valid.
- If the ID'd entry is FREE, WAIT_SQ or READY, ignore the response.

Branch resolve, for every non-FREE entry with (bm & b_mm_resolve) != 0:
- If b_mm_mispred=1, the entry is killed:
  - WAIT_SQ or READY entries go to FREE.
  - ISSUED entries go to ZOMBIE.
- Otherwise, clear those bits: bm &= ~b_mm_resolve.
- The incoming alloc_bm gets the same treatment. On a mispredicting match no entry is allocated; otherwise the cleared mask is stored.

Simultaneous events:
- Response and kill of the same ISSUED entry in one cycle: the entry goes to FREE and produces no done_valid.
- A READY entry killed in the cycle it would issue: it is not selected, and the next READY entry is selected instead.
- Kill on a non-mispredict resolve does not block issue.
- load_buffer_free is computed from registered state only. An entry freed this cycle is allocatable next cycle.

## Timing
- Reset values: all entries FREE; load_buffer_free=1; dcache_req_valid=0; done_valid=0; done_dest=0; done_data=0.
- Reset mid-operation discards every entry, including ISSUED and ZOMBIE entries. Any later response is ignored.
- Minimum latency:
  - Edge N: allocation.
  - Edge N+1: WAIT_SQ to READY, if sq_head already matches.
  - Cycle after N+1: dcache_req_valid=1.
- done_valid, done_dest and done_data are registered. They are high for exactly one cycle, the cycle after the response edge.
- dcache_req_valid may stay high across stall cycles. While ready=0, the selected ID and address are stable unless a kill or a lower-index READY entry intervenes.

## Test plan
- Allocate addr 0x100, dest 5, sq_tail 2, with sq_head=2 → request (addr 0x100, id 0) two cycles later. Respond with 0xDEADBEEF → done_valid with dest 5 and 0xDEADBEEF the next cycle.
- Fill all 4 entries → load_buffer_free=0. Respond to id 2 → load_buffer_free=1 the next cycle, and a new allocation lands in entry 2.
- Entry with sq_tail 3 while sq_head=1 → no request. Advance sq_head to 3 (including a 7→0 wrap case) → request follows.
- Hold dcache_req_ready=0 for 3 cycles with entries 1 and 3 READY → id 1 is presented stably. Assert ready → id 3 is presented next.
- Issue entry 0 with bm 0010, then resolve 0010 with mispred=1 → entry 0 goes to ZOMBIE. Its response produces no done_valid, and entry 0 becomes allocatable the following cycle.
- Allocate with bm 0100 in the same cycle as resolve 0100 with mispred=0 → the entry is stored with bm 0000. Repeat with mispred=1 → no allocation, and load_buffer_free is unchanged.

Source files
------------

// File: rtl/load_buffer_ctrl.sv
// Load buffer between address generation and the data-cache load port: holds loads
// until older stores drain, issues them in index order, and matches out-of-order responses.
module load_buffer_ctrl #(
  parameter  int NUM_ENTRIES = 4,
  parameter  int ADDR_W      = 32,
  parameter  int TAG_W       = 6,
  parameter  int BM_W        = 4,
  parameter  int SQ_W        = 3,
  localparam int ID_W        = $clog2(NUM_ENTRIES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [TAG_W-1:0]  alloc_dest,
  input  logic [BM_W-1:0]   alloc_bm,
  input  logic [SQ_W-1:0]   alloc_sq_tail,
  output logic              load_buffer_free,
  input  logic [SQ_W-1:0]   sq_head,
  output logic              dcache_req_valid,
  output logic [ADDR_W-1:0] dcache_req_addr,
  output logic [ID_W-1:0]   dcache_req_id,
  input  logic              dcache_req_ready,
  input  logic              dcache_resp_valid,
  input  logic [ID_W-1:0]   dcache_resp_id,
  input  logic [31:0]       dcache_resp_data,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_dest,
  output logic [31:0]       done_data,
  input  logic [BM_W-1:0]   b_mm_resolve,
  input  logic              b_mm_mispred
);

  typedef enum logic [2:0] {
    ST_FREE    = 3'd0,
    ST_WAIT_SQ = 3'd1,
    ST_READY   = 3'd2,
    ST_ISSUED  = 3'd3,
    ST_ZOMBIE  = 3'd4
  } entry_state_e;

  entry_state_e      state_q   [NUM_ENTRIES];
  entry_state_e      state_d   [NUM_ENTRIES];
  logic [ADDR_W-1:0] addr_q    [NUM_ENTRIES];
  logic [ADDR_W-1:0] addr_d    [NUM_ENTRIES];
  logic [TAG_W-1:0]  dest_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]  dest_d    [NUM_ENTRIES];
  logic [BM_W-1:0]   bm_q      [NUM_ENTRIES];
  logic [BM_W-1:0]   bm_d      [NUM_ENTRIES];
  logic [SQ_W-1:0]   sq_tail_q [NUM_ENTRIES];
  logic [SQ_W-1:0]   sq_tail_d [NUM_ENTRIES];

  logic              done_valid_q, done_valid_d;
  logic [TAG_W-1:0]  done_dest_q, done_dest_d;
  logic [31:0]       done_data_q, done_data_d;

  logic [NUM_ENTRIES-1:0] is_free;
  logic [NUM_ENTRIES-1:0] kill;
  logic [NUM_ENTRIES-1:0] issuable;
  logic [NUM_ENTRIES-1:0] sq_match;
  logic [NUM_ENTRIES-1:0] resp_hit;
  logic [NUM_ENTRIES-1:0] alloc_sel;
  logic [NUM_ENTRIES-1:0] grant;

  logic [ID_W-1:0]   alloc_idx;
  logic [ID_W-1:0]   issue_idx;
  logic              issue_fire;
  logic              alloc_bm_match;
  logic              alloc_en;
  logic [BM_W-1:0]   alloc_bm_clean;

  // A kill only ever comes from a mispredicted resolve hitting a live entry.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry_flags
      assign is_free[gi]   = (state_q[gi] == ST_FREE);
      assign kill[gi]      = !is_free[gi] && b_mm_mispred && (|(bm_q[gi] & b_mm_resolve));
      assign issuable[gi]  = (state_q[gi] == ST_READY) && !kill[gi];
      assign sq_match[gi]  = (sq_head == sq_tail_q[gi]);
      assign resp_hit[gi]  = dcache_resp_valid && (dcache_resp_id == ID_W'(gi));
      assign alloc_sel[gi] = alloc_en && (alloc_idx == ID_W'(gi));
      assign grant[gi]     = issue_fire && (issue_idx == ID_W'(gi));
    end
  endgenerate

  // Lowest-index priority encoders; scanning downward lets the lowest match win.
  always_comb begin
    alloc_idx = '0;
    issue_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (is_free[i]) begin
        alloc_idx = ID_W'(i);
      end
      if (issuable[i]) begin
        issue_idx = ID_W'(i);
      end
    end
  end

  assign load_buffer_free = |is_free;
  assign alloc_bm_match   = |(alloc_bm & b_mm_resolve);
  assign alloc_en         = alloc_valid && load_buffer_free && !(alloc_bm_match && b_mm_mispred);
  assign alloc_bm_clean   = alloc_bm & ~b_mm_resolve;

  assign dcache_req_valid = |issuable;
  assign dcache_req_addr  = addr_q[issue_idx];
  assign dcache_req_id    = issue_idx;
  assign issue_fire       = dcache_req_valid && dcache_req_ready;

  // A response racing with a kill of the same entry is discarded.
  assign done_valid_d = dcache_resp_valid && (state_q[dcache_resp_id] == ST_ISSUED)
                        && !kill[dcache_resp_id];
  assign done_dest_d  = dest_q[dcache_resp_id];
  assign done_data_d  = dcache_resp_data;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i]   = state_q[i];
      addr_d[i]    = addr_q[i];
      dest_d[i]    = dest_q[i];
      sq_tail_d[i] = sq_tail_q[i];
      bm_d[i]      = b_mm_mispred ? bm_q[i] : (bm_q[i] & ~b_mm_resolve);
      case (state_q[i])
        ST_FREE: begin
          if (alloc_sel[i]) begin
            state_d[i]   = ST_WAIT_SQ;
            addr_d[i]    = alloc_addr;
            dest_d[i]    = alloc_dest;
            bm_d[i]      = alloc_bm_clean;
            sq_tail_d[i] = alloc_sq_tail;
          end
        end
        ST_WAIT_SQ: begin
          if (kill[i]) begin
            state_d[i] = ST_FREE;
          end else if (sq_match[i]) begin
            state_d[i] = ST_READY;
          end
        end
        ST_READY: begin
          if (kill[i]) begin
            state_d[i] = ST_FREE;
          end else if (grant[i]) begin
            state_d[i] = ST_ISSUED;
          end
        end
        ST_ISSUED: begin
          if (resp_hit[i]) begin
            state_d[i] = ST_FREE;
          end else if (kill[i]) begin
            state_d[i] = ST_ZOMBIE;
          end
        end
        ST_ZOMBIE: begin
          if (resp_hit[i]) begin
            state_d[i] = ST_FREE;
          end
        end
        default: begin
          state_d[i] = ST_FREE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i]   <= ST_FREE;
        addr_q[i]    <= '0;
        dest_q[i]    <= '0;
        bm_q[i]      <= '0;
        sq_tail_q[i] <= '0;
      end
      done_valid_q <= 1'b0;
      done_dest_q  <= '0;
      done_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i]   <= state_d[i];
        addr_q[i]    <= addr_d[i];
        dest_q[i]    <= dest_d[i];
        bm_q[i]      <= bm_d[i];
        sq_tail_q[i] <= sq_tail_d[i];
      end
      done_valid_q <= done_valid_d;
      if (done_valid_d) begin
        done_dest_q <= done_dest_d;
        done_data_q <= done_data_d;
      end
    end
  end

  assign done_valid = done_valid_q;
  assign done_dest  = done_dest_q;
  assign done_data  = done_data_q;

endmodule

// File: tb/tb_load_buffer_ctrl.sv
// Scoreboard bench for load_buffer_ctrl: expected cache requests and completions are
// queued when stimulus is driven and checked by a negedge monitor.
module tb_load_buffer_ctrl;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 6;
  localparam int BM_W   = 4;
  localparam int SQ_W   = 3;
  localparam int ID_W   = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic [ADDR_W-1:0] alloc_addr;
  logic [TAG_W-1:0]  alloc_dest;
  logic [BM_W-1:0]   alloc_bm;
  logic [SQ_W-1:0]   alloc_sq_tail;
  logic              load_buffer_free;
  logic [SQ_W-1:0]   sq_head;
  logic              dcache_req_valid;
  logic [ADDR_W-1:0] dcache_req_addr;
  logic [ID_W-1:0]   dcache_req_id;
  logic              dcache_req_ready;
  logic              dcache_resp_valid;
  logic [ID_W-1:0]   dcache_resp_id;
  logic [31:0]       dcache_resp_data;
  logic              done_valid;
  logic [TAG_W-1:0]  done_dest;
  logic [31:0]       done_data;
  logic [BM_W-1:0]   b_mm_resolve;
  logic              b_mm_mispred;

  load_buffer_ctrl dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_dest(alloc_dest),
    .alloc_bm(alloc_bm), .alloc_sq_tail(alloc_sq_tail), .load_buffer_free(load_buffer_free),
    .sq_head(sq_head),
    .dcache_req_valid(dcache_req_valid), .dcache_req_addr(dcache_req_addr),
    .dcache_req_id(dcache_req_id), .dcache_req_ready(dcache_req_ready),
    .dcache_resp_valid(dcache_resp_valid), .dcache_resp_id(dcache_resp_id),
    .dcache_resp_data(dcache_resp_data),
    .done_valid(done_valid), .done_dest(done_dest), .done_data(done_data),
    .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
  } req_t;

  typedef struct packed {
    logic [TAG_W-1:0] dest;
    logic [31:0]      data;
  } done_t;

  req_t  exp_req  [$];
  done_t exp_done [$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change only here, one time unit after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_r(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id);
    exp_req.push_back('{addr: a, id: id});
  endtask

  task automatic do_alloc(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] d,
                          input logic [BM_W-1:0] bm, input logic [SQ_W-1:0] t);
    alloc_addr    = a;
    alloc_dest    = d;
    alloc_bm      = bm;
    alloc_sq_tail = t;
    alloc_valid   = 1'b1;
    tick();
    alloc_valid   = 1'b0;
  endtask

  task automatic respond(input logic [ID_W-1:0] id, input logic [31:0] data,
                         input bit expect_done, input logic [TAG_W-1:0] dest);
    if (expect_done) exp_done.push_back('{dest: dest, data: data});
    dcache_resp_id    = id;
    dcache_resp_data  = data;
    dcache_resp_valid = 1'b1;
    tick();
    dcache_resp_valid = 1'b0;
  endtask

  task automatic issue_cycles(input int n);
    dcache_req_ready = 1'b1;
    repeat (n) tick();
    dcache_req_ready = 1'b0;
  endtask

  task automatic sb_sample();
    req_t  er;
    done_t ed;
    if (dcache_req_valid && dcache_req_ready) begin
      if (exp_req.size() == 0) begin
        check_eq("req_unexpected", 64'(dcache_req_valid), 64'd0);
      end else begin
        er = exp_req.pop_front();
        $display("req  id=%0d addr=0x%0h", dcache_req_id, dcache_req_addr);
        check_eq("req_addr", 64'(dcache_req_addr), 64'(er.addr));
        check_eq("req_id", 64'(dcache_req_id), 64'(er.id));
      end
    end
    if (done_valid) begin
      if (exp_done.size() == 0) begin
        check_eq("done_unexpected", 64'(done_valid), 64'd0);
      end else begin
        ed = exp_done.pop_front();
        $display("done dest=%0d data=0x%0h", done_dest, done_data);
        check_eq("done_dest", 64'(done_dest), 64'(ed.dest));
        check_eq("done_data", 64'(done_data), 64'(ed.data));
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) sb_sample();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    alloc_valid = 1'b0; alloc_addr = '0; alloc_dest = '0; alloc_bm = '0; alloc_sq_tail = '0;
    sq_head = '0; dcache_req_ready = 1'b0;
    dcache_resp_valid = 1'b0; dcache_resp_id = '0; dcache_resp_data = '0;
    b_mm_resolve = '0; b_mm_mispred = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_free", 64'(load_buffer_free), 64'd1);
    check_eq("rst_req_valid", 64'(dcache_req_valid), 64'd0);
    check_eq("rst_done_valid", 64'(done_valid), 64'd0);
    check_eq("rst_done_dest", 64'(done_dest), 64'd0);
    check_eq("rst_done_data", 64'(done_data), 64'd0);

    // Basic load: request two edges after allocation, completion one cycle after response.
    tick();
    sq_head = 3'd2;
    do_alloc(32'h100, 6'd5, 4'b0000, 3'd2);
    @(negedge clock);
    check_eq("t1_wait_no_req", 64'(dcache_req_valid), 64'd0);
    tick();
    @(negedge clock);
    check_eq("t1_req_valid", 64'(dcache_req_valid), 64'd1);
    check_eq("t1_req_addr", 64'(dcache_req_addr), 64'h100);
    check_eq("t1_req_id", 64'(dcache_req_id), 64'd0);
    tick();
    exp_r(32'h100, 2'd0);
    issue_cycles(1);
    @(negedge clock);
    check_eq("t1_issued_no_req", 64'(dcache_req_valid), 64'd0);
    tick();
    respond(2'd0, 32'hDEADBEEF, 1'b1, 6'd5);
    @(negedge clock);
    check_eq("t1_done_valid", 64'(done_valid), 64'd1);
    tick();
    @(negedge clock);
    check_eq("t1_done_pulse", 64'(done_valid), 64'd0);

    // Fill, ignore an overflow allocation, free id 2 and reallocate into it.
    tick();
    for (int i = 0; i < 4; i++) do_alloc(32'h200 + 32'(4 * i), 6'(10 + i), 4'b0000, 3'd2);
    @(negedge clock);
    check_eq("t2_full", 64'(load_buffer_free), 64'd0);
    tick();
    do_alloc(32'h2F0, 6'd60, 4'b0000, 3'd2);
    for (int i = 0; i < 4; i++) exp_r(32'h200 + 32'(4 * i), 2'(i));
    issue_cycles(4);
    respond(2'd2, 32'h22222222, 1'b1, 6'd12);
    alloc_addr = 32'h300; alloc_dest = 6'd20; alloc_bm = 4'b0000; alloc_sq_tail = 3'd2;
    alloc_valid = 1'b1;
    @(negedge clock);
    check_eq("t2_free_after_resp", 64'(load_buffer_free), 64'd1);
    tick();
    alloc_valid = 1'b0;
    @(negedge clock);
    check_eq("t2_refilled", 64'(load_buffer_free), 64'd0);
    tick();
    @(negedge clock);
    check_eq("t2_realloc_id", 64'(dcache_req_id), 64'd2);
    tick();
    exp_r(32'h300, 2'd2);
    issue_cycles(1);
    respond(2'd0, 32'hA0000000, 1'b1, 6'd10);
    respond(2'd1, 32'hA0000001, 1'b1, 6'd11);
    respond(2'd3, 32'hA0000003, 1'b1, 6'd13);
    respond(2'd2, 32'hA0000002, 1'b1, 6'd20);

    // Store-queue ordering, including head wrap 7 -> 0.
    sq_head = 3'd1;
    do_alloc(32'h400, 6'd30, 4'b0000, 3'd3);
    repeat (3) begin
      @(negedge clock);
      check_eq("t3_blocked", 64'(dcache_req_valid), 64'd0);
      tick();
    end
    sq_head = 3'd3;
    tick();
    @(negedge clock);
    check_eq("t3_released", 64'(dcache_req_valid), 64'd1);
    tick();
    exp_r(32'h400, 2'd0);
    issue_cycles(1);
    respond(2'd0, 32'h44444444, 1'b1, 6'd30);
    sq_head = 3'd7;
    do_alloc(32'h410, 6'd31, 4'b0000, 3'd0);
    repeat (2) begin
      @(negedge clock);
      check_eq("t3_wrap_blocked", 64'(dcache_req_valid), 64'd0);
      tick();
    end
    sq_head = 3'd0;
    tick();
    @(negedge clock);
    check_eq("t3_wrap_addr", 64'(dcache_req_addr), 64'h410);
    tick();
    exp_r(32'h410, 2'd0);
    issue_cycles(1);
    respond(2'd0, 32'h41041041, 1'b1, 6'd31);

    // Stall with entries 1 and 3 READY.
    do_alloc(32'h500, 6'd40, 4'b0000, 3'd5);
    do_alloc(32'h504, 6'd41, 4'b0000, 3'd0);
    do_alloc(32'h508, 6'd42, 4'b0000, 3'd5);
    do_alloc(32'h50C, 6'd43, 4'b0000, 3'd0);
    tick();
    repeat (3) begin
      @(negedge clock);
      check_eq("t4_stall_valid", 64'(dcache_req_valid), 64'd1);
      check_eq("t4_stall_id", 64'(dcache_req_id), 64'd1);
      check_eq("t4_stall_addr", 64'(dcache_req_addr), 64'h504);
      tick();
    end
    exp_r(32'h504, 2'd1);
    exp_r(32'h50C, 2'd3);
    dcache_req_ready = 1'b1;
    tick();
    @(negedge clock);
    check_eq("t4_next_id", 64'(dcache_req_id), 64'd3);
    tick();
    dcache_req_ready = 1'b0;
    sq_head = 3'd5;
    exp_r(32'h500, 2'd0);
    exp_r(32'h508, 2'd2);
    issue_cycles(3);
    for (int i = 0; i < 4; i++) respond(2'(i), 32'h50000000 + 32'(i), 1'b1, 6'(40 + i));

    // Squash after issue: zombie response is dropped, entry reusable next cycle.
    do_alloc(32'h600, 6'd50, 4'b0010, 3'd5);
    tick();
    exp_r(32'h600, 2'd0);
    issue_cycles(1);
    b_mm_resolve = 4'b0010; b_mm_mispred = 1'b1;
    tick();
    b_mm_resolve = 4'b0000; b_mm_mispred = 1'b0;
    @(negedge clock);
    check_eq("t5_zombie_no_req", 64'(dcache_req_valid), 64'd0);
    tick();
    respond(2'd0, 32'h66666666, 1'b0, 6'd0);
    alloc_addr = 32'h700; alloc_dest = 6'd51; alloc_bm = 4'b0000; alloc_sq_tail = 3'd5;
    alloc_valid = 1'b1;
    @(negedge clock);
    check_eq("t5_zombie_no_done", 64'(done_valid), 64'd0);
    tick();
    alloc_valid = 1'b0;
    tick();
    @(negedge clock);
    check_eq("t5_realloc_id", 64'(dcache_req_id), 64'd0);
    check_eq("t5_realloc_addr", 64'(dcache_req_addr), 64'h700);
    tick();
    exp_r(32'h700, 2'd0);
    issue_cycles(1);
    respond(2'd0, 32'h77777777, 1'b1, 6'd51);

    // Response and kill of the same issued entry in one cycle.
    do_alloc(32'h780, 6'd52, 4'b0001, 3'd5);
    tick();
    exp_r(32'h780, 2'd0);
    issue_cycles(1);
    b_mm_resolve = 4'b0001; b_mm_mispred = 1'b1;
    respond(2'd0, 32'h78787878, 1'b0, 6'd0);
    b_mm_resolve = 4'b0000; b_mm_mispred = 1'b0;
    @(negedge clock);
    check_eq("t5b_no_done", 64'(done_valid), 64'd0);
    tick();

    // Killed READY entry is skipped in favour of the next one in the same cycle.
    do_alloc(32'h800, 6'd53, 4'b0001, 3'd5);
    do_alloc(32'h804, 6'd54, 4'b0000, 3'd5);
    tick();
    exp_r(32'h804, 2'd1);
    dcache_req_ready = 1'b1;
    b_mm_resolve = 4'b0001; b_mm_mispred = 1'b1;
    @(negedge clock);
    check_eq("t5c_kill_skip_id", 64'(dcache_req_id), 64'd1);
    tick();
    dcache_req_ready = 1'b0;
    b_mm_resolve = 4'b0000; b_mm_mispred = 1'b0;
    @(negedge clock);
    check_eq("t5c_none_left", 64'(dcache_req_valid), 64'd0);
    tick();
    respond(2'd1, 32'h88888888, 1'b1, 6'd54);

    // Resolve against the incoming allocation.
    alloc_addr = 32'h900; alloc_dest = 6'd55; alloc_bm = 4'b0100; alloc_sq_tail = 3'd1;
    alloc_valid = 1'b1;
    b_mm_resolve = 4'b0100; b_mm_mispred = 1'b0;
    tick();
    alloc_valid = 1'b0;
    b_mm_mispred = 1'b1;
    tick();
    b_mm_resolve = 4'b0000; b_mm_mispred = 1'b0;
    sq_head = 3'd1;
    tick();
    @(negedge clock);
    check_eq("t6_cleared_bm_survives", 64'(dcache_req_valid), 64'd1);
    check_eq("t6_cleared_bm_id", 64'(dcache_req_id), 64'd0);
    tick();
    exp_r(32'h900, 2'd0);
    issue_cycles(1);
    respond(2'd0, 32'h99999999, 1'b1, 6'd55);
    for (int i = 0; i < 3; i++) do_alloc(32'hB00 + 32'(4 * i), 6'(56 + i), 4'b1000, 3'd6);
    alloc_addr = 32'hC00; alloc_dest = 6'd59; alloc_bm = 4'b0100; alloc_sq_tail = 3'd1;
    alloc_valid = 1'b1;
    b_mm_resolve = 4'b0100; b_mm_mispred = 1'b1;
    tick();
    alloc_valid = 1'b0;
    b_mm_resolve = 4'b0000; b_mm_mispred = 1'b0;
    @(negedge clock);
    check_eq("t6_kill_alloc_free", 64'(load_buffer_free), 64'd1);
    tick();
    b_mm_resolve = 4'b1000; b_mm_mispred = 1'b1;
    tick();
    b_mm_resolve = 4'b0000; b_mm_mispred = 1'b0;
    tick();
    @(negedge clock);
    check_eq("t6_kill_alloc_no_req", 64'(dcache_req_valid), 64'd0);
    tick();

    // Reset while a load is in flight; its late response must be ignored.
    do_alloc(32'hA00, 6'd60, 4'b0000, 3'd1);
    tick();
    exp_r(32'hA00, 2'd0);
    issue_cycles(1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    respond(2'd0, 32'hAAAAAAAA, 1'b0, 6'd0);
    @(negedge clock);
    check_eq("t7_no_done", 64'(done_valid), 64'd0);
    check_eq("t7_no_req", 64'(dcache_req_valid), 64'd0);
    check_eq("t7_free", 64'(load_buffer_free), 64'd1);
    tick();
    tick();

    check_eq("sb_req_left", 64'(exp_req.size()), 64'd0);
    check_eq("sb_done_left", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
